cpu_run_monitor: RTL and testbench

//  Hardware run controller for the 8-bit CPU. Sequences CPU clear, gates the ring-counter enable,

---
 rtl/cpu_pkg.sv | 15 +
 rtl/run_log_fifo.sv | 59 +++++
 rtl/cpu_run_monitor.sv | 138 +++++++++++++
 tb/tb_cpu_run_monitor.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU run controller: run-state encoding and opcode defaults.
package cpu_pkg;

    localparam int unsigned          OPCODE_W       = 8;
    localparam logic [OPCODE_W-1:0]  HLT_OPCODE_DEF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR     = 3'd1,
        ST_RUN     = 3'd2,
        ST_HALTED  = 3'd3,
        ST_TIMEOUT = 3'd4
    } run_state_t;

endpackage

// File: rtl/run_log_fifo.sv
// Synchronous show-ahead FIFO for the run log; sticky overflow flags dropped pushes.
module run_log_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic             do_wr, do_rd;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data  = mem_q[rd_ptr_q[AW-1:0]];
    assign overflow = ovf_q;

    // Pointer/overflow next state; a pop frees the slot a same-cycle push on full needs.
    always_comb begin
        do_rd    = rd_en && !empty;
        do_wr    = wr_en && (!full || do_rd);
        wr_ptr_d = wr_ptr_q + (do_wr ? {{AW{1'b0}}, 1'b1} : '0);
        rd_ptr_d = rd_ptr_q + (do_rd ? {{AW{1'b0}}, 1'b1} : '0);
        ovf_d    = ovf_q || (wr_en && !do_wr);
    end

    // Pointer and overflow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array, written only on accepted pushes.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller for the 8-bit CPU: clear sequencing, run gating, HLT detect,
// watchdog, and timestamped logging of output-register changes.
module cpu_run_monitor
    import cpu_pkg::*;
#(
    parameter int unsigned          DATA_W         = 8,
    parameter int unsigned          OPCODE_W       = cpu_pkg::OPCODE_W,
    parameter logic [OPCODE_W-1:0]  HLT_OPCODE     = cpu_pkg::HLT_OPCODE_DEF,
    parameter int unsigned          CLEAR_CYCLES   = 2,
    parameter int unsigned          TIMEOUT_CYCLES = 3000,
    parameter int unsigned          CNT_W          = 16,
    parameter int unsigned          LOG_DEPTH      = 8
) (
    input  logic                      clk,
    input  logic                      clear,
    input  logic                      start,
    input  logic [OPCODE_W-1:0]       opcode,
    input  logic                      opcode_valid,
    input  logic [DATA_W-1:0]         cpu_data_out,
    output logic                      cpu_clear,
    output logic                      cpu_run,
    output logic [2:0]                run_state,
    output logic                      halted,
    output logic                      timed_out,
    output logic [CNT_W-1:0]          cycle_count,
    input  logic                      log_rd_en,
    output logic [CNT_W+DATA_W-1:0]   log_rd_data,
    output logic                      log_empty,
    output logic                      log_full,
    output logic                      log_overflow
);

    localparam int unsigned CLR_W = (CLEAR_CYCLES < 2) ? 1 : $clog2(CLEAR_CYCLES);

    run_state_t        state_q, state_d;
    logic [CLR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              halted_q, halted_d;
    logic              timed_out_q, timed_out_d;
    logic              cpu_clear_q, cpu_clear_d;
    logic              cpu_run_q, cpu_run_d;
    logic              log_push;

    // Next-state logic; the log timestamp is the post-increment count so it
    // numbers RUN cycles from 1, matching cycle_count after a HLT on that cycle.
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        cycle_count_d = cycle_count_q;
        last_d        = last_q;
        halted_d      = halted_q;
        timed_out_d   = timed_out_q;
        log_push      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_HALTED, ST_TIMEOUT: begin
                if (start) begin
                    state_d       = ST_CLR;
                    clr_cnt_d     = '0;
                    cycle_count_d = '0;
                    last_d        = '0;
                    halted_d      = 1'b0;
                    timed_out_d   = 1'b0;
                end
            end
            ST_CLR: begin
                if (clr_cnt_q == CLR_W'(CLEAR_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + CLR_W'(1);
                end
            end
            ST_RUN: begin
                cycle_count_d = cycle_count_q + CNT_W'(1);
                if (cpu_data_out != last_q) begin
                    log_push = 1'b1;
                    last_d   = cpu_data_out;
                end
                if (opcode_valid && (opcode == HLT_OPCODE)) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else if (cycle_count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = ST_TIMEOUT;
                    timed_out_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        cpu_clear_d = (state_d == ST_IDLE) || (state_d == ST_CLR);
        cpu_run_d   = (state_d == ST_RUN);
    end

    // FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q       <= ST_IDLE;
            clr_cnt_q     <= '0;
            cycle_count_q <= '0;
            last_q        <= '0;
            halted_q      <= 1'b0;
            timed_out_q   <= 1'b0;
            cpu_clear_q   <= 1'b1;
            cpu_run_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            cycle_count_q <= cycle_count_d;
            last_q        <= last_d;
            halted_q      <= halted_d;
            timed_out_q   <= timed_out_d;
            cpu_clear_q   <= cpu_clear_d;
            cpu_run_q     <= cpu_run_d;
        end
    end

    assign cpu_clear   = cpu_clear_q;
    assign cpu_run     = cpu_run_q;
    assign run_state   = state_q;
    assign halted      = halted_q;
    assign timed_out   = timed_out_q;
    assign cycle_count = cycle_count_q;

    run_log_fifo #(
        .WIDTH (CNT_W + DATA_W),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk      (clk),
        .rst      (clear),
        .wr_en    (log_push),
        .wr_data  ({cycle_count_d, cpu_data_out}),
        .rd_en    (log_rd_en),
        .rd_data  (log_rd_data),
        .empty    (log_empty),
        .full     (log_full),
        .overflow (log_overflow)
    );

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed self-checking bench for cpu_run_monitor (TIMEOUT_CYCLES=20, LOG_DEPTH=8).
module tb_cpu_run_monitor;

    localparam int unsigned TMO = 20;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  opcode = 8'h00;
    logic        opcode_valid = 1'b0;
    logic [7:0]  cpu_data_out = 8'h00;
    logic        cpu_clear, cpu_run, halted, timed_out;
    logic [2:0]  run_state;
    logic [15:0] cycle_count;
    logic        log_rd_en = 1'b0;
    logic [23:0] log_rd_data;
    logic        log_empty, log_full, log_overflow;

    int checks = 0;
    int failures = 0;

    cpu_run_monitor #(
        .DATA_W         (8),
        .OPCODE_W       (8),
        .HLT_OPCODE     (8'h0A),
        .CLEAR_CYCLES   (2),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (16),
        .LOG_DEPTH      (8)
    ) dut (
        .clk          (clk),
        .clear        (clear),
        .start        (start),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .cpu_data_out (cpu_data_out),
        .cpu_clear    (cpu_clear),
        .cpu_run      (cpu_run),
        .run_state    (run_state),
        .halted       (halted),
        .timed_out    (timed_out),
        .cycle_count  (cycle_count),
        .log_rd_en    (log_rd_en),
        .log_rd_data  (log_rd_data),
        .log_empty    (log_empty),
        .log_full     (log_full),
        .log_overflow (log_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start from a resting state and advance through the two CLR cycles.
    task automatic enter_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (run_state !== 3'd2) begin
            failures++;
            $display("FAIL enter_run state got=%0d exp=2", run_state);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        tick();
        tick();
        checks++;
        if ({run_state, cpu_clear, cpu_run, halted, timed_out} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_ctrl got st=%0d clr=%b run=%b h=%b t=%b exp st=0 clr=1 run=0 h=0 t=0",
                     run_state, cpu_clear, cpu_run, halted, timed_out);
        end
        checks++;
        if ({cycle_count, log_empty, log_full, log_overflow} !== {16'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_log got cnt=%0d e=%b f=%b o=%b exp cnt=0 e=1 f=0 o=0",
                     cycle_count, log_empty, log_full, log_overflow);
        end
        clear = 1'b0;
        tick();
        checks++;
        if (run_state !== 3'd0) begin
            failures++;
            $display("FAIL idle_hold state got=%0d exp=0", run_state);
        end
    endtask

    task automatic test_halt();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({run_state, cpu_clear, cpu_run} !== {3'd1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL clr_entry got st=%0d clr=%b run=%b exp st=1 clr=1 run=0", run_state, cpu_clear, cpu_run);
        end
        tick();
        checks++;
        if (run_state !== 3'd1) begin
            failures++;
            $display("FAIL clr_second state got=%0d exp=1", run_state);
        end
        tick();
        checks++;
        if ({run_state, cpu_clear, cpu_run, cycle_count} !== {3'd2, 1'b0, 1'b1, 16'd0}) begin
            failures++;
            $display("FAIL run_entry got st=%0d clr=%b run=%b cnt=%0d exp st=2 clr=0 run=1 cnt=0",
                     run_state, cpu_clear, cpu_run, cycle_count);
        end
        for (int k = 1; k <= 10; k++) begin
            cpu_data_out = (k >= 4) ? 8'h05 : 8'h00;
            opcode       = (k == 5 || k == 10) ? 8'h0A : 8'h01;
            opcode_valid = (k != 5);
            tick();
        end
        opcode_valid = 1'b0;
        checks++;
        if ({run_state, halted, timed_out, cpu_run, cpu_clear} !== {3'd3, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL halt_state got st=%0d h=%b t=%b run=%b clr=%b exp st=3 h=1 t=0 run=0 clr=0",
                     run_state, halted, timed_out, cpu_run, cpu_clear);
        end
        checks++;
        if (cycle_count !== 16'd10) begin
            failures++;
            $display("FAIL halt_count got=%0d exp=10", cycle_count);
        end
        checks++;
        if ({log_empty, log_rd_data} !== {1'b0, 16'd4, 8'h05}) begin
            failures++;
            $display("FAIL halt_log got e=%b data=%h exp e=0 data=000405", log_empty, log_rd_data);
        end
        tick();
        checks++;
        if ({cycle_count, run_state} !== {16'd10, 3'd3}) begin
            failures++;
            $display("FAIL halt_frozen got cnt=%0d st=%0d exp cnt=10 st=3", cycle_count, run_state);
        end
    endtask

    task automatic test_restart();
        int n;
        cpu_data_out = 8'h00;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({cycle_count, halted} !== {16'd0, 1'b0}) begin
            failures++;
            $display("FAIL restart_clr got cnt=%0d h=%b exp cnt=0 h=0", cycle_count, halted);
        end
        n = 0;
        for (int w = 0; w < 10 && run_state != 3'd2; w++) begin
            if (cpu_clear) n++;
            tick();
        end
        checks++;
        if ({n, run_state, cpu_clear} !== {32'd2, 3'd2, 1'b0}) begin
            failures++;
            $display("FAIL restart_clear_len got n=%0d st=%0d clr=%b exp n=2 st=2 clr=0", n, run_state, cpu_clear);
        end
        opcode = 8'h0A;
        opcode_valid = 1'b1;
        tick();
        opcode_valid = 1'b0;
        checks++;
        if ({run_state, cycle_count} !== {3'd3, 16'd1}) begin
            failures++;
            $display("FAIL restart_halt got st=%0d cnt=%0d exp st=3 cnt=1", run_state, cycle_count);
        end
        checks++;
        if ({log_empty, log_rd_data} !== {1'b0, 16'd4, 8'h05}) begin
            failures++;
            $display("FAIL restart_oldlog got e=%b data=%h exp e=0 data=000405", log_empty, log_rd_data);
        end
        log_rd_en = 1'b1;
        tick();
        log_rd_en = 1'b0;
        checks++;
        if (log_empty !== 1'b1) begin
            failures++;
            $display("FAIL restart_pop empty got=%b exp=1", log_empty);
        end
    endtask

    task automatic test_timeout();
        cpu_data_out = 8'h00;
        enter_run();
        for (int k = 1; k <= int'(TMO) - 1; k++) begin
            start = (k == 5);
            tick();
        end
        start = 1'b0;
        checks++;
        if ({run_state, cycle_count} !== {3'd2, 16'(TMO - 1)}) begin
            failures++;
            $display("FAIL tmo_pre got st=%0d cnt=%0d exp st=2 cnt=%0d", run_state, cycle_count, TMO - 1);
        end
        tick();
        checks++;
        if ({run_state, timed_out, halted, cpu_run, cycle_count} !== {3'd4, 1'b1, 1'b0, 1'b0, 16'(TMO)}) begin
            failures++;
            $display("FAIL tmo_fire got st=%0d t=%b h=%b run=%b cnt=%0d exp st=4 t=1 h=0 run=0 cnt=%0d",
                     run_state, timed_out, halted, cpu_run, cycle_count, TMO);
        end
        checks++;
        if (log_empty !== 1'b1) begin
            failures++;
            $display("FAIL tmo_nolog empty got=%b exp=1", log_empty);
        end
    endtask

    task automatic test_hlt_at_watchdog();
        enter_run();
        for (int k = 1; k <= int'(TMO) - 1; k++) tick();
        opcode = 8'h0A;
        opcode_valid = 1'b1;
        tick();
        opcode_valid = 1'b0;
        checks++;
        if ({run_state, halted, timed_out, cycle_count} !== {3'd3, 1'b1, 1'b0, 16'(TMO)}) begin
            failures++;
            $display("FAIL hlt_wd got st=%0d h=%b t=%b cnt=%0d exp st=3 h=1 t=0 cnt=%0d",
                     run_state, halted, timed_out, cycle_count, TMO);
        end
    endtask

    task automatic test_back_to_back();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        enter_run();
        for (int k = 1; k <= 8; k++) begin
            cpu_data_out = 8'(k);
            tick();
        end
        checks++;
        if ({log_full, log_overflow, log_rd_data} !== {1'b1, 1'b0, 16'd1, 8'd1}) begin
            failures++;
            $display("FAIL b2b_full got f=%b o=%b data=%h exp f=1 o=0 data=000101", log_full, log_overflow, log_rd_data);
        end
        cpu_data_out = 8'd9;
        log_rd_en = 1'b1;
        tick();
        log_rd_en = 1'b0;
        checks++;
        if ({log_full, log_overflow, log_rd_data} !== {1'b1, 1'b0, 16'd2, 8'd2}) begin
            failures++;
            $display("FAIL b2b_pushpop got f=%b o=%b data=%h exp f=1 o=0 data=000202", log_full, log_overflow, log_rd_data);
        end
        opcode = 8'h0A;
        opcode_valid = 1'b1;
        tick();
        opcode_valid = 1'b0;
        for (int k = 2; k <= 9; k++) begin
            checks++;
            if (log_rd_data !== {16'(k), 8'(k)}) begin
                failures++;
                $display("FAIL b2b_drain%0d got=%h exp=%h", k, log_rd_data, {16'(k), 8'(k)});
            end
            log_rd_en = 1'b1;
            tick();
            log_rd_en = 1'b0;
        end
        checks++;
        if (log_empty !== 1'b1) begin
            failures++;
            $display("FAIL b2b_empty got=%b exp=1", log_empty);
        end
    endtask

    task automatic test_overflow();
        clear = 1'b1;
        cpu_data_out = 8'h00;
        tick();
        clear = 1'b0;
        enter_run();
        for (int k = 1; k <= 10; k++) begin
            cpu_data_out = 8'(k);
            tick();
        end
        opcode = 8'h0A;
        opcode_valid = 1'b1;
        tick();
        opcode_valid = 1'b0;
        checks++;
        if ({log_full, log_overflow, run_state} !== {1'b1, 1'b1, 3'd3}) begin
            failures++;
            $display("FAIL ovf_flags got f=%b o=%b st=%0d exp f=1 o=1 st=3", log_full, log_overflow, run_state);
        end
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (log_rd_data !== {16'(k), 8'(k)}) begin
                failures++;
                $display("FAIL ovf_order%0d got=%h exp=%h", k, log_rd_data, {16'(k), 8'(k)});
            end
            log_rd_en = 1'b1;
            tick();
            log_rd_en = 1'b0;
        end
        log_rd_en = 1'b1;
        tick();
        log_rd_en = 1'b0;
        checks++;
        if ({log_empty, log_overflow} !== {1'b1, 1'b1}) begin
            failures++;
            $display("FAIL ovf_sticky got e=%b o=%b exp e=1 o=1", log_empty, log_overflow);
        end
    endtask

    task automatic test_clear_midrun();
        cpu_data_out = 8'h00;
        enter_run();
        cpu_data_out = 8'h33;
        tick();
        tick();
        checks++;
        if ({run_state, log_empty} !== {3'd2, 1'b0}) begin
            failures++;
            $display("FAIL mid_pre got st=%0d e=%b exp st=2 e=0", run_state, log_empty);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if ({run_state, cpu_clear, cpu_run, cycle_count} !== {3'd0, 1'b1, 1'b0, 16'd0}) begin
            failures++;
            $display("FAIL mid_clear_ctrl got st=%0d clr=%b run=%b cnt=%0d exp st=0 clr=1 run=0 cnt=0",
                     run_state, cpu_clear, cpu_run, cycle_count);
        end
        checks++;
        if ({log_empty, log_overflow, log_full} !== {1'b1, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mid_clear_log got e=%b o=%b f=%b exp e=1 o=0 f=0", log_empty, log_overflow, log_full);
        end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_restart();
        test_timeout();
        test_hlt_at_watchdog();
        test_back_to_back();
        test_overflow();
        test_clear_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
